// File: rtl/rll_pkg.sv
// Shared types and defaults for the RLL key loader slice.
package rll_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT = 16;
    localparam int unsigned TIMEOUT_DEFAULT   = 64;

    // 1: a frame is good when the total number of ones (key + parity bit) is even.
    localparam bit PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ARMED,
        ERROR
    } key_state_e;

endpackage

// File: rtl/rll_key_shreg.sv
// Indexed shadow register for the incoming key, with a running parity accumulator.
module rll_key_shreg
    import rll_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter int unsigned IDX_W     = $clog2(KEY_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic                 load_bit,
    output logic [KEY_WIDTH-1:0] shadow,
    output logic                 parity_ok
);

    logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
    logic                 acc_q, acc_d;

    // Index KEY_WIDTH is the parity bit: it only feeds the accumulator.
    always_comb begin
        shadow_d = shadow_q;
        acc_d    = acc_q;
        if (clr) begin
            shadow_d = '0;
            acc_d    = 1'b0;
        end else if (load_en) begin
            for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
                if (load_idx == IDX_W'(i)) begin
                    shadow_d[i] = load_bit;
                end
            end
            acc_d = acc_q ^ load_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            acc_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
        end
    end

    assign shadow    = shadow_q;
    assign parity_ok = (acc_q != PARITY_EVEN);

endmodule

// File: rtl/rll_key_loader.sv
// Loads a parity-checked serial key and drives it onto the locked core once verified.
module rll_key_loader
    import rll_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 ser_ready,
    input  logic                 zeroize,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned BW = $clog2(KEY_WIDTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(KEY_WIDTH);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    key_state_e           state_q, state_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;

    logic                 xfer;
    logic                 sh_clr;
    logic                 sh_load;
    logic [KEY_WIDTH-1:0] shadow;
    logic                 parity_ok;

    assign xfer = ser_valid && (state_q == LOAD);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        tcnt_d   = tcnt_q;
        key_d    = key_q;
        sh_clr   = 1'b0;
        sh_load  = 1'b0;
        if (zeroize) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            tcnt_d   = '0;
            key_d    = '0;
            sh_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = LOAD;
                        bitcnt_d = '0;
                        tcnt_d   = '0;
                        sh_clr   = 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        sh_load  = 1'b1;
                        bitcnt_d = bitcnt_q + 1'b1;
                        tcnt_d   = '0;
                        if (bitcnt_q == LAST_IDX) begin
                            state_d = CHECK;
                        end
                    end else begin
                        // Saturating idle count; hitting the limit aborts the frame.
                        if (tcnt_q < TMAX) begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                        if (tcnt_d == TMAX) begin
                            state_d = ERROR;
                        end
                    end
                end
                CHECK: begin
                    if (parity_ok) begin
                        state_d = ARMED;
                        key_d   = shadow;
                    end else begin
                        state_d = ERROR;
                        sh_clr  = 1'b1;
                    end
                end
                ARMED: begin
                end
                ERROR: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            tcnt_q   <= tcnt_d;
            key_q    <= key_d;
        end
    end

    rll_key_shreg #(
        .KEY_WIDTH (KEY_WIDTH),
        .IDX_W     (BW)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (sh_clr),
        .load_en   (sh_load),
        .load_idx  (bitcnt_q),
        .load_bit  (ser_data),
        .shadow    (shadow),
        .parity_ok (parity_ok)
    );

    // key_q is only written on the CHECK->ARMED edge and cleared on zeroize/reset.
    assign key_out   = key_q;
    assign key_valid = (state_q == ARMED);
    assign busy      = (state_q == LOAD) || (state_q == CHECK);
    assign error     = (state_q == ERROR);
    assign ser_ready = (state_q == LOAD);

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench: directed scenarios plus randomized frames against a frame-level model.
module tb_rll_key_loader;

    localparam int KW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ser_valid = 1'b0;
    logic          ser_data = 1'b0;
    logic          ser_ready;
    logic          zeroize = 1'b0;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic          error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rll_key_loader #(
        .KEY_WIDTH (KW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .zeroize   (zeroize),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .error     (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"}, {ser_ready, busy, error, key_valid, key_out}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ser_valid = 1'b0;
        zeroize = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle_outputs("reset");
    endtask

    task automatic do_zeroize();
        zeroize = 1'b1;
        start = 1'b1;
        ser_valid = 1'b1;
        tick();
        zeroize = 1'b0;
        start = 1'b0;
        ser_valid = 1'b0;
        check_idle_outputs("zeroize");
    endtask

    // Frame-level model: good iff the popcount of {par,key} is even and no idle run
    // of TO cycles happens before the parity bit is accepted.
    task automatic run_frame(input logic [KW-1:0] key, input logic par, input int gap,
                             input int stall_bit, input int stall_len, output bit armed);
        logic [KW:0] frame;
        int          idle;
        int          cyc;
        int          n;
        bit          good;
        frame = {par, key};
        good  = ($countones(frame) % 2) == 0;
        idle  = 0;
        armed = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check("start_busy", busy, 1);
        for (int b = 0; b <= KW; b++) begin
            n = (b == stall_bit) ? stall_len : gap;
            for (int g = 0; g < n; g++) begin
                ser_valid = 1'b0;
                ser_data = 1'($urandom);
                tick();
                cyc++;
                idle++;
                check("idle_err", error, (idle >= TO) ? 1 : 0);
                if (idle >= TO) begin
                    check("to_ready", ser_ready, 0);
                    check("to_key", {key_valid, key_out}, 0);
                    // Error is sticky: start and stream traffic are ignored.
                    start = 1'b1;
                    ser_valid = 1'b1;
                    tick();
                    start = 1'b0;
                    tick();
                    ser_valid = 1'b0;
                    check("to_sticky", {error, ser_ready, busy}, 3'b100);
                    return;
                end
            end
            check("ready", ser_ready, 1);
            ser_valid = 1'b1;
            ser_data = frame[b];
            tick();
            cyc++;
            idle = 0;
            ser_valid = 1'b0;
            check("mid_key", {key_valid, key_out}, 0);
        end
        check("chk_state", {busy, ser_ready, error}, 3'b100);
        tick();
        cyc++;
        if (good) begin
            check("armed_valid", {key_valid, error, busy}, 3'b100);
            check("armed_key", key_out, key);
            if (gap == 0 && stall_bit < 0) begin
                check("latency", cyc, 1 + (KW + 1) + 1);
            end
            armed = 1'b1;
        end else begin
            check("bad_err", {error, key_valid, ser_ready}, 3'b100);
            check("bad_key", key_out, 0);
        end
    endtask

    initial begin
        bit          armed;
        logic [KW-1:0] k;
        logic        p;
        int          gap;
        int          sb;
        int          sl;

        do_reset();
        check_idle_outputs("idle2");

        // Good load, back-to-back
        run_frame(16'hA5C3, 1'b0, 0, -1, 0, armed);

        // Armed immutability
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ser_valid = 1'b1;
            ser_data = 1'b1;
            tick();
            check("imm_key", key_out, 16'hA5C3);
            check("imm_flags", {key_valid, ser_ready, busy}, 3'b100);
        end
        ser_valid = 1'b0;
        do_zeroize();

        // zeroize wins over start in IDLE
        tick();
        check("zero_over_start", busy, 0);

        // Bad parity
        run_frame(16'hA5C3, 1'b1, 0, -1, 0, armed);
        do_zeroize();

        // Timeout after 5 bits
        run_frame(16'hA5C3, 1'b0, 0, 5, 64, armed);
        do_zeroize();

        // One short of the timeout must still arm
        run_frame(16'hA5C3, 1'b0, 0, 9, 63, armed);
        do_zeroize();

        // Reset mid-frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ser_valid = 1'b1;
            ser_data = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
        do_reset();
        run_frame(16'h1234, 1'b1, 0, -1, 0, armed);
        do_zeroize();

        // Stalled stream
        run_frame(16'hA5C3, 1'b0, 3, -1, 0, armed);
        do_zeroize();

        // Randomized frames
        for (int t = 0; t < 30; t++) begin
            k = KW'($urandom);
            p = ^k;
            if ($urandom_range(0, 3) == 0) p = ~p;
            gap = $urandom_range(0, 2);
            sb = -1;
            sl = 0;
            if ($urandom_range(0, 4) == 0) begin
                sb = $urandom_range(0, KW);
                sl = $urandom_range(TO - 1, TO);
            end
            // Traffic while not ready must be ignored.
            for (int i = 0; i < 2; i++) begin
                ser_valid = 1'b1;
                ser_data = 1'($urandom);
                tick();
            end
            ser_valid = 1'b0;
            run_frame(k, p, gap, sb, sl, armed);
            do_zeroize();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
- Provisions the 16-bit unlock key for an RLL-locked combinational netlist.
- Accepts the key as a serial, parity-protected frame over a valid/ready stream and checks the parity.
- Drives the key onto the locked core's key inputs only after a successful check. key_out[k] drives keyIn_0_k.
- Sits between the secure key store / scan port and the locked core.

Parameters:
- KEY_WIDTH, 16: number of key bits, equal to the keyIn_0_* count of the locked core.
- TIMEOUT, 64: maximum idle cycles allowed between accepted serial bits while loading.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load frame. Honoured only in IDLE.
- ser_valid  in  1  serial bit offered.
- ser_data  in  1  serial key/parity bit.
- ser_ready  out  1  loader accepts a bit this cycle.
- zeroize  in  1  clears the key and returns to IDLE. Highest priority after reset.
- key_out  out  KEY_WIDTH  key to the locked core; all-zero unless ARMED.
- key_valid  out  1  high in ARMED only.
- busy  out  1  high in LOAD and CHECK.
- error  out  1  sticky high in ERROR.

Behaviour:
- Reset (rst_n=0 at a clk edge), effective next cycle:
  - state=IDLE; shadow register, bit counter and timeout counter = 0.
  - key_out=0, key_valid=0, ser_ready=0, busy=0, error=0.
  - A reset mid-frame discards the partial key.
- Frame format: KEY_WIDTH key bits LSB first, then 1 even-parity bit. Total ones over all KEY_WIDTH+1 bits must be even.
- Bit transfer occurs when ser_valid && ser_ready at a clk edge.
- States and transitions:
  - IDLE: ser_ready=0. start=1 → LOAD, counters cleared.
  - LOAD: ser_ready=1, busy=1.
    - Each transfer stores the bit into shadow[bitcnt], increments bitcnt and clears the timeout counter.
    - The transfer with bitcnt==KEY_WIDTH is the parity bit. It is latched, then → CHECK.
    - A cycle with no transfer increments the timeout counter. On reaching TIMEOUT → ERROR.
    - The timeout counter saturates and never wraps.
  - CHECK: exactly one cycle, ser_ready=0.
    - Parity good → ARMED.
    - Parity bad → ERROR, and shadow is cleared.
  - ARMED: key_out=shadow and key_valid=1 from the first ARMED cycle, i.e. 1 cycle after the parity transfer plus the CHECK cycle.
    - start and ser_valid are ignored; the key is immutable while armed.
  - ERROR: error=1, key_out=0, ser_ready=0. Only zeroize or reset leaves this state (→ IDLE).
- zeroize=1 in any state, next edge: state=IDLE, shadow=0, key_out=0, key_valid=0, error=0. It overrides a simultaneous start or transfer.
- start while in LOAD, CHECK, ARMED or ERROR is ignored.
- ser_valid while ser_ready=0 is ignored; no bit is consumed.
- key_out is registered. It never shows a partial or unchecked key, even for one cycle.
- Widths:
  - bitcnt is $clog2(KEY_WIDTH+1) bits.
  - The timeout counter is $clog2(TIMEOUT+1) bits.
  - The parity accumulator is 1-bit XOR.
- Total load latency from start to key_valid = 1 + (KEY_WIDTH+1 transfer cycles) + 1, i.e. 19 cycles for back-to-back bits at the defaults.

Decomposition:
- Shared package rll_pkg holds:
  - KEY_WIDTH_DEFAULT=16 and TIMEOUT_DEFAULT=64.
  - The state enum key_state_e {IDLE, LOAD, CHECK, ARMED, ERROR}.
  - The parity polarity constant PARITY_EVEN=1.
- One sub-module is natural: rll_key_shreg.
  - Indexed shadow register with parity accumulator and synchronous clear.
  - Load-enable/index input, parity_ok output.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Good load: reset, start, then bits of 16'hA5C3 LSB first and parity 0, back-to-back. Required: key_valid=1 and key_out=16'hA5C3 at cycle 19 after start; error=0.
- Bad parity: same key with parity 1. Required: error=1 after CHECK; key_out=16'h0000 and key_valid=0 throughout.
- Timeout: start, send 5 bits, then hold ser_valid=0 for 64 cycles. Required: error=1 on the cycle the count reaches 64; ser_ready=0 afterwards.
- Armed immutability and zeroize:
  - After the good load, pulse start and stream 16'hFFFF. Required: key_out stays 16'hA5C3.
  - Then assert zeroize. Required: next cycle key_out=0, key_valid=0, state IDLE.
- Reset mid-frame: rst_n=0 after 8 bits, release, then do a full good load of 16'h1234 with parity 1. Required: key_out=16'h1234 with no residue from the aborted frame.
- Stalled stream: good 16'hA5C3 frame with ser_valid deasserted for 3 cycles between every bit. Required: key_valid=1 with key_out=16'hA5C3 and no timeout.
